// File: rtl/frequency_capture_sequencer_if.sv
// Register-write port between the frequency capture sequencer and the AXI
// register file. The sequencer presents one write at a time and holds it
// until the register file raises register_ready.
interface frequency_capture_sequencer_if;
   logic [1:0]  register_operation;
   logic [7:0]  register_number;
   logic [31:0] register_write;
   logic        register_ready;

   modport master (
      output register_operation,
      output register_number,
      output register_write,
      input  register_ready
   );

   modport slave (
      input  register_operation,
      input  register_number,
      input  register_write,
      output register_ready
   );
endinterface

// File: rtl/frequency_capture_sequencer.sv
// Pixel frequency analyser sequencer.
// Each channel watches one bit of one pixel position per line, measures the
// half-period between changes of that bit and accumulates the time spent near
// two target half-periods. On stop the 2*CHANNELS accumulators are written out
// through the register-write port and irq is pulsed.
//
// state | meaning
// IDLE  | waiting for start; capture logic held cleared
// RUN   | sampling pixels, measuring and accumulating half-periods
// DUMP  | presenting registers 1..2*CHANNELS, one per accepted write
// DONE  | single cycle, irq high, then back to IDLE
module frequency_capture_sequencer #(
   parameter int unsigned            CHANNELS            = 3,
   parameter int unsigned            DATA_WIDTH          = 8,
   parameter int unsigned            SAMPLE_BIT          = 7,
   parameter int unsigned            PIXEL_COUNTER_WIDTH = 12,
   parameter int unsigned            LINE_LENGTH         = 1024,
   parameter logic [CHANNELS*16-1:0] PIXEL_INDEXES       = {16'd1023, 16'd511, 16'd63},
   parameter logic [CHANNELS*32-1:0] F0_HALF_PERIODS     = {3{32'd100}},
   parameter logic [CHANNELS*32-1:0] F1_HALF_PERIODS     = {3{32'd200}},
   parameter int unsigned            DEVIATION_CYCLES    = 20
) (
   input  logic                          s00_axi_aclk,
   input  logic                          s00_axi_aresetn,
   input  logic [DATA_WIDTH-1:0]         data,
   input  logic                          pixel_valid,
   input  logic                          line_start,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          clear,
   frequency_capture_sequencer_if.master reg_if,
   output logic                          busy,
   output logic                          irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DUMP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [PIXEL_COUNTER_WIDTH-1:0] LAST_PIX = PIXEL_COUNTER_WIDTH'(LINE_LENGTH - 1);
   localparam logic [7:0]  LAST_NUM = 8'(2 * CHANNELS);
   localparam logic [32:0] DEV      = 33'(DEVIATION_CYCLES);
   localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
   localparam logic [1:0]  OP_WRITE = 2'd2;

   state_t state_q, state_d;

   logic [PIXEL_COUNTER_WIDTH-1:0] pix_cnt_q, pix_cnt_d, pix_idx;

   logic [CHANNELS-1:0] sample_q, sample_d;
   logic [CHANNELS-1:0] seen_q, seen_d;
   logic [31:0]         hp_cnt_q [CHANNELS];
   logic [31:0]         hp_cnt_d [CHANNELS];
   logic [31:0]         acc_f0_q [CHANNELS];
   logic [31:0]         acc_f0_d [CHANNELS];
   logic [31:0]         acc_f1_q [CHANNELS];
   logic [31:0]         acc_f1_d [CHANNELS];
   logic [32:0]         measured;
   logic                meas_vld;
   logic                clear_ok;

   logic [1:0]  op_q, op_d;
   logic [7:0]  num_q, num_d;
   logic [31:0] wr_q, wr_d;
   logic [7:0]  next_num;
   logic [31:0] next_val;

   logic data_unused;

   // only SAMPLE_BIT of the pixel word is analysed
   assign data_unused = ^data;

   // clear has no effect once the results are being dumped
   assign clear_ok = clear && ((state_q == IDLE) || (state_q == RUN));

   function automatic logic in_window(input logic [32:0] m, input logic [31:0] f);
      logic [32:0] diff;
      diff = (m >= {1'b0, f}) ? (m - {1'b0, f}) : ({1'b0, f} - m);
      return diff <= DEV;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [32:0] b);
      logic [33:0] sum;
      sum = {2'b00, a} + {1'b0, b};
      return (sum > {2'b00, CNT_MAX}) ? CNT_MAX : sum[31:0];
   endfunction

   // in-line pixel position; line_start makes the current pixel index 0
   always_comb begin
      pix_idx   = line_start ? '0 : pix_cnt_q;
      pix_cnt_d = pix_cnt_q;
      if (state_q != RUN) begin
         pix_cnt_d = '0;
      end else if (pixel_valid) begin
         pix_cnt_d = (pix_idx == LAST_PIX) ? '0 : pix_idx + 1'b1;
      end
   end

   // per-channel sampling, half-period measurement and accumulation
   always_comb begin
      measured = '0;
      meas_vld = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         sample_d[k] = sample_q[k];
         seen_d[k]   = seen_q[k];
         hp_cnt_d[k] = hp_cnt_q[k];
         acc_f0_d[k] = acc_f0_q[k];
         acc_f1_d[k] = acc_f1_q[k];
         measured    = '0;
         meas_vld    = 1'b0;
         if (state_q != RUN) begin
            sample_d[k] = 1'b0;
            seen_d[k]   = 1'b0;
            hp_cnt_d[k] = '0;
         end else begin
            if (pixel_valid && (32'(pix_idx) == 32'(PIXEL_INDEXES[16*k +: 16]))) begin
               sample_d[k] = data[SAMPLE_BIT];
            end
            if (sample_d[k] != sample_q[k]) begin
               // the first change after entering RUN only starts the timing
               measured    = {1'b0, hp_cnt_q[k]} + 33'd1;
               meas_vld    = seen_q[k];
               seen_d[k]   = 1'b1;
               hp_cnt_d[k] = '0;
            end else if (hp_cnt_q[k] != CNT_MAX) begin
               hp_cnt_d[k] = hp_cnt_q[k] + 32'd1;
            end
         end
         if (clear_ok) begin
            acc_f0_d[k] = '0;
            acc_f1_d[k] = '0;
         end else if (meas_vld) begin
            if (in_window(measured, F0_HALF_PERIODS[32*k +: 32])) begin
               acc_f0_d[k] = sat_add(acc_f0_q[k], measured);
            end else if (in_window(measured, F1_HALF_PERIODS[32*k +: 32])) begin
               acc_f1_d[k] = sat_add(acc_f1_q[k], measured);
            end
         end
      end
   end

   // value of the register that follows the one currently presented
   always_comb begin
      next_num = num_q + 8'd1;
      next_val = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (next_num == 8'(2*k + 1)) next_val = acc_f0_q[k];
         if (next_num == 8'(2*k + 2)) next_val = acc_f1_q[k];
      end
   end

   // sequencing and registered write-port outputs
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      num_d   = num_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (stop) begin
               // first register carries any accumulation made this cycle
               state_d = DUMP;
               op_d    = OP_WRITE;
               num_d   = 8'd1;
               wr_d    = acc_f0_d[0];
            end
         end
         DUMP: begin
            if (reg_if.register_ready) begin
               if (num_q == LAST_NUM) begin
                  state_d = DONE;
                  op_d    = '0;
                  num_d   = '0;
                  wr_d    = '0;
               end else begin
                  num_d = next_num;
                  wr_d  = next_val;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            op_d    = '0;
            num_d   = '0;
            wr_d    = '0;
         end
      endcase
   end

   // state and write-port registers
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q <= IDLE;
         op_q    <= '0;
         num_q   <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         num_q   <= num_d;
         wr_q    <= wr_d;
      end
   end

   // pixel position register
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         pix_cnt_q <= '0;
      end else begin
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // per-channel sample, timer and accumulator registers
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         sample_q <= '0;
         seen_q   <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            hp_cnt_q[k] <= '0;
            acc_f0_q[k] <= '0;
            acc_f1_q[k] <= '0;
         end
      end else begin
         sample_q <= sample_d;
         seen_q   <= seen_d;
         for (int k = 0; k < CHANNELS; k++) begin
            hp_cnt_q[k] <= hp_cnt_d[k];
            acc_f0_q[k] <= acc_f0_d[k];
            acc_f1_q[k] <= acc_f1_d[k];
         end
      end
   end

   assign reg_if.register_operation = op_q;
   assign reg_if.register_number    = num_q;
   assign reg_if.register_write     = wr_q;
   assign busy = (state_q == RUN) || (state_q == DUMP);
   assign irq  = (state_q == DONE);

endmodule

// File: tb/tb_frequency_capture_sequencer.sv
// Bench for frequency_capture_sequencer: two channels on pixels 3 and 7 of a
// 10-pixel line. The reference keeps the cycle stamp of every change of each
// channel's bit and derives the expected accumulators from the gaps between
// consecutive stamps.
`timescale 1ns/1ps
module tb_frequency_capture_sequencer;
   localparam int NREG = 4;
   localparam int LINE = 10;
   localparam int IDX0 = 3;
   localparam int IDX1 = 7;
   localparam int F0   = 20;
   localparam int F1   = 50;
   localparam int DEV  = 2;

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic [7:0] data = '0;
   logic       pixel_valid = 1'b0;
   logic       line_start = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clear = 1'b0;
   logic       busy;
   logic       irq;

   frequency_capture_sequencer_if reg_if ();

   frequency_capture_sequencer #(
      .CHANNELS(2), .DATA_WIDTH(8), .SAMPLE_BIT(7), .PIXEL_COUNTER_WIDTH(12),
      .LINE_LENGTH(10), .PIXEL_INDEXES({16'd7, 16'd3}),
      .F0_HALF_PERIODS({32'd20, 32'd20}), .F1_HALF_PERIODS({32'd50, 32'd50}),
      .DEVIATION_CYCLES(2)
   ) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .data(data),
      .pixel_valid(pixel_valid), .line_start(line_start), .start(start),
      .stop(stop), .clear(clear), .reg_if(reg_if), .busy(busy), .irq(irq)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   int          ts0[$];
   int          ts1[$];
   int          clr_t = -1;
   int unsigned exp_reg [NREG];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int pick_period();
      case ($urandom_range(0, 3))
         0: return 1;
         1: return 2;
         2: return 3;
         default: return 5;
      endcase
   endfunction

   // gaps between consecutive bit changes are the half-periods; a gap ending
   // at or before the last clear does not survive it
   function automatic void model_channel(input int q[$], input int clr,
                                         output int unsigned a0, output int unsigned a1);
      a0 = 0;
      a1 = 0;
      for (int i = 1; i < q.size(); i++) begin
         int d;
         d = q[i] - q[i-1];
         if (q[i] > clr) begin
            if (iabs(d - F0) <= DEV) a0 += d;
            else if (iabs(d - F1) <= DEV) a1 += d;
         end
      end
   endfunction

   task automatic compute_expected();
      model_channel(ts0, clr_t, exp_reg[0], exp_reg[1]);
      model_channel(ts1, clr_t, exp_reg[2], exp_reg[3]);
   endtask

   task automatic set_exp(input int unsigned r1, input int unsigned r2,
                          input int unsigned r3, input int unsigned r4);
      exp_reg[0] = r1;
      exp_reg[1] = r2;
      exp_reg[2] = r3;
      exp_reg[3] = r4;
   endtask

   task automatic clear_idle();
      pixel_valid = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic start_run(input bit with_stop);
      ts0.delete();
      ts1.delete();
      clr_t = -1;
      pixel_valid = 1'b0;
      start = 1'b1;
      stop = with_stop;
      step();
      start = 1'b0;
      stop = 1'b0;
      check("run_busy", busy, 1);
      check("run_no_dump", reg_if.register_operation, 0);
   endtask

   // channel k toggles its bit on its first pixel and then every per_k lines
   // (random periods in rnd mode) until tog_k toggles are done
   task automatic run_lines(input int nlines, input int per0, input int tog0,
                            input int per1, input int tog1, input bit rnd, input int clear_line);
      int   left [2];
      int   tg [2];
      int   per [2];
      int   maxt [2];
      logic bitv [2];
      int   p;
      bit   mid_used;
      bit   ls;
      logic [7:0] d;
      per[0] = per0; per[1] = per1;
      maxt[0] = tog0; maxt[1] = tog1;
      for (int k = 0; k < 2; k++) begin
         left[k] = 0;
         tg[k] = 0;
         bitv[k] = 1'b0;
      end
      for (int L = 0; L < nlines; L++) begin
         p = 0;
         mid_used = 1'b0;
         while (p < LINE) begin
            d = 8'($urandom);
            ls = (p == 0);
            if (rnd && p == 0 && $urandom_range(0, 3) == 0) ls = 1'b0;
            if (rnd && p != 0 && !mid_used && $urandom_range(0, 29) == 0) begin
               ls = 1'b1;
               p = 0;
               mid_used = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
               if (p == ((k == 0) ? IDX0 : IDX1)) begin
                  if (left[k] == 0 && tg[k] < maxt[k]) begin
                     bitv[k] = ~bitv[k];
                     tg[k]++;
                     left[k] = (rnd ? pick_period() : per[k]) - 1;
                     if (k == 0) ts0.push_back(cyc);
                     else ts1.push_back(cyc);
                  end else if (left[k] > 0) begin
                     left[k]--;
                  end
                  d[7] = bitv[k];
               end
            end
            clear = (L == clear_line) && (p == 0);
            start = rnd && (L == 1) && (p == 0);
            if (clear) clr_t = cyc;
            pixel_valid = 1'b1;
            line_start = ls;
            data = d;
            step();
            p++;
            if (rnd && $urandom_range(0, 15) == 0) begin
               pixel_valid = 1'b0;
               line_start = 1'b0;
               clear = 1'b0;
               start = 1'b0;
               data = 8'($urandom);
               repeat ($urandom_range(1, 2)) step();
            end
         end
      end
      pixel_valid = 1'b0;
      line_start = 1'b0;
      clear = 1'b0;
      start = 1'b0;
   endtask

   // stop, then follow the dump; register stall_num is refused for
   // stall_cycles cycles; abort_num pulls reset while that register is shown
   task automatic dump_check(input int stall_num, input int stall_cycles, input int abort_num);
      int n;
      int cycles;
      int stalls;
      pixel_valid = 1'b0;
      line_start = 1'b0;
      reg_if.register_ready = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      n = 1;
      cycles = 0;
      stalls = 0;
      while (n <= NREG && cycles < 40) begin
         cycles++;
         check("dump_op", reg_if.register_operation, 2);
         check("dump_num", reg_if.register_number, n);
         check("dump_value", reg_if.register_write, exp_reg[n-1]);
         check("dump_busy", busy, 1);
         clear = (cycles == 1);
         if (n == abort_num) begin
            #2 aresetn = 1'b0;
            #1;
            check("abort_op", reg_if.register_operation, 0);
            check("abort_num", reg_if.register_number, 0);
            check("abort_value", reg_if.register_write, 0);
            check("abort_busy", busy, 0);
            check("abort_irq", irq, 0);
            clear = 1'b0;
            reg_if.register_ready = 1'b0;
            repeat (2) begin
               step();
               check("abort_no_irq", irq, 0);
            end
            aresetn = 1'b1;
            return;
         end
         if (n == stall_num && stalls < stall_cycles) begin
            reg_if.register_ready = 1'b0;
            stalls++;
         end else begin
            reg_if.register_ready = 1'b1;
            n++;
         end
         step();
      end
      clear = 1'b0;
      reg_if.register_ready = 1'b0;
      check("dump_length", cycles, NREG + stall_cycles);
      check("done_op", reg_if.register_operation, 0);
      check("done_num", reg_if.register_number, 0);
      check("done_value", reg_if.register_write, 0);
      check("done_irq", irq, 1);
      check("done_busy", busy, 0);
      step();
      check("idle_irq", irq, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reg_if.register_ready = 1'b0;
      repeat (3) step();
      check("reset_op", reg_if.register_operation, 0);
      check("reset_num", reg_if.register_number, 0);
      check("reset_value", reg_if.register_write, 0);
      check("reset_busy", busy, 0);
      check("reset_irq", irq, 0);
      aresetn = 1'b1;
      step();

      // stop alone in IDLE does nothing
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("idle_stop_busy", busy, 0);
      check("idle_stop_op", reg_if.register_operation, 0);

      // f0 on channel 0, start and stop together arm RUN
      clear_idle();
      start_run(1'b1);
      run_lines(10, 2, 5, 0, 0, 1'b0, -1);
      set_exp(80, 0, 0, 0);
      dump_check(0, 0, 0);

      // f1 on channel 1
      clear_idle();
      start_run(1'b0);
      run_lines(11, 0, 0, 5, 3, 1'b0, -1);
      set_exp(0, 0, 0, 100);
      dump_check(0, 0, 0);

      // half-period 30 sits outside both windows
      clear_idle();
      start_run(1'b0);
      run_lines(10, 3, 4, 3, 4, 1'b0, -1);
      set_exp(0, 0, 0, 0);
      dump_check(0, 0, 0);

      // register 2 refused for three cycles
      clear_idle();
      start_run(1'b0);
      run_lines(10, 2, 5, 0, 0, 1'b0, -1);
      set_exp(80, 0, 0, 0);
      dump_check(2, 3, 0);

      // clear after 80 accumulated, then two more f0 half-periods
      clear_idle();
      start_run(1'b0);
      run_lines(14, 2, 7, 0, 0, 1'b0, 9);
      set_exp(40, 0, 0, 0);
      dump_check(0, 0, 0);

      // reset while register 2 is presented, then a fresh capture
      clear_idle();
      start_run(1'b0);
      run_lines(10, 2, 5, 0, 0, 1'b0, -1);
      set_exp(80, 0, 0, 0);
      dump_check(0, 0, 2);
      step();
      start_run(1'b0);
      run_lines(11, 0, 0, 5, 3, 1'b0, -1);
      set_exp(0, 0, 0, 100);
      dump_check(0, 0, 0);

      // randomized traffic: random periods, pixel gaps, line_start placement
      for (int it = 0; it < 4; it++) begin
         int nl;
         int cl;
         int sn;
         int sc;
         clear_idle();
         nl = int'($urandom_range(16, 30));
         cl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, nl - 2)) : -1;
         sn = int'($urandom_range(1, NREG));
         sc = int'($urandom_range(0, 3));
         start_run(1'b0);
         run_lines(nl, 0, 1000, 0, 1000, 1'b1, cl);
         compute_expected();
         dump_check(sn, sc, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
